// File: rtl/axi4_sram_pkg.sv
// Shared types and constants for the AXI4 SRAM responder.
package axi4_sram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_WRESP,
    ST_RFETCH,
    ST_RDATA
  } state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] SIZE_8B = 2'b11;

  // Requests outside the window, unaligned, not 8-byte beats, or WRAP/reserved bursts are errors.
  function automatic logic req_err(input logic [31:0] addr, input logic [1:0] size,
                                   input logic [1:0] burst, input int unsigned aw);
    logic out_of_window;
    logic bad_burst;
    out_of_window = (addr >> (aw + 32'd3)) != 32'd0;
    bad_burst     = !((burst == BURST_FIXED) || (burst == BURST_INCR));
    return out_of_window || (addr[2:0] != 3'd0) || (size != SIZE_8B) || bad_burst;
  endfunction

endpackage

// File: rtl/sram_sp_be.sv
// Single-port synchronous RAM, 64-bit words with byte enables, one-cycle read latency.
module sram_sp_be #(
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [7:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  localparam int unsigned DEPTH = 32'd1 << AW;

  logic [63:0] mem [DEPTH];

  // Contents are deliberately not reset; rdata holds until the next read.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 8; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/axi4_sram_slave.sv
// AXI4 responder backed by a byte-enabled on-chip SRAM; one burst in flight at a time.
module axi4_sram_slave
  import axi4_sram_pkg::*;
#(
  parameter int unsigned MEM_AW = 10
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic [3:0]  awid_i,
  input  logic [31:0] awaddr_i,
  input  logic [7:0]  awlen_i,
  input  logic [1:0]  awsize_i,
  input  logic [1:0]  awburst_i,
  input  logic        awvalid_i,
  output logic        awready_o,
  input  logic [63:0] wdata_i,
  input  logic [7:0]  wstrb_i,
  input  logic        wlast_i,
  input  logic        wvalid_i,
  output logic        wready_o,
  output logic [3:0]  bid_o,
  output logic [1:0]  bresp_o,
  output logic        bvalid_o,
  input  logic        bready_i,
  input  logic [3:0]  arid_i,
  input  logic [31:0] araddr_i,
  input  logic [7:0]  arlen_i,
  input  logic [1:0]  arsize_i,
  input  logic [1:0]  arburst_i,
  input  logic        arvalid_i,
  output logic        arready_o,
  output logic [3:0]  rid_o,
  output logic [63:0] rdata_o,
  output logic [1:0]  rresp_o,
  output logic        rlast_o,
  output logic        rvalid_o,
  input  logic        rready_i
);

  localparam int unsigned CW = 9;

  state_e              state, state_next;
  logic                aw_hs, ar_hs, w_hs, r_hs;
  logic [3:0]          id_q;
  logic [MEM_AW-1:0]   idx_q, idx_next;
  logic [7:0]          len_q;
  logic [1:0]          burst_q;
  logic                err_q;
  logic [CW-1:0]       cnt_q, cnt_inc, len_ext;
  logic [1:0]          bresp_q;
  logic                at_last, in_len;
  logic                ram_en, ram_we;
  logic [63:0]         ram_rdata;

  assign aw_hs = (state == ST_IDLE) && awvalid_i;
  assign ar_hs = (state == ST_IDLE) && !awvalid_i && arvalid_i;
  assign w_hs  = (state == ST_WDATA) && wvalid_i;
  assign r_hs  = (state == ST_RDATA) && rready_i;

  assign len_ext  = {1'b0, len_q};
  assign at_last  = cnt_q == len_ext;
  assign in_len   = cnt_q <= len_ext;
  assign cnt_inc  = (cnt_q == len_ext + CW'(1)) ? cnt_q : cnt_q + CW'(1);
  assign idx_next = (burst_q == BURST_INCR) ? idx_q + MEM_AW'(1) : idx_q;

  assign bid_o   = id_q;
  assign rid_o   = id_q;
  assign bresp_o = bresp_q;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) state <= ST_IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (aw_hs)      state_next = ST_WDATA;
        else if (ar_hs) state_next = ST_RFETCH;
      end
      ST_WDATA:  if (w_hs && wlast_i) state_next = ST_WRESP;
      ST_WRESP:  if (bready_i) state_next = ST_IDLE;
      ST_RFETCH: state_next = ST_RDATA;
      ST_RDATA:  if (r_hs && at_last) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Handshake outputs and RAM control; the read for the next beat fires on each R accept.
  always_comb begin
    awready_o = 1'b0;
    arready_o = 1'b0;
    wready_o  = 1'b0;
    bvalid_o  = 1'b0;
    rvalid_o  = 1'b0;
    rlast_o   = 1'b0;
    rdata_o   = 64'd0;
    rresp_o   = RESP_OKAY;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        awready_o = 1'b1;
        arready_o = !awvalid_i;
      end
      ST_WDATA: begin
        wready_o = 1'b1;
        ram_en   = w_hs;
        ram_we   = w_hs && !err_q && in_len;
      end
      ST_WRESP:  bvalid_o = 1'b1;
      ST_RFETCH: ram_en = 1'b1;
      ST_RDATA: begin
        rvalid_o = 1'b1;
        rlast_o  = at_last;
        rdata_o  = err_q ? 64'd0 : ram_rdata;
        rresp_o  = err_q ? RESP_SLVERR : RESP_OKAY;
        ram_en   = r_hs;
      end
      default: ;
    endcase
  end

  // Burst context: latched at address accept, advanced per beat.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      id_q    <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      bresp_q <= RESP_OKAY;
    end else if (aw_hs) begin
      id_q    <= awid_i;
      idx_q   <= awaddr_i[MEM_AW+2:3];
      len_q   <= awlen_i;
      burst_q <= awburst_i;
      err_q   <= req_err(awaddr_i, awsize_i, awburst_i, MEM_AW);
      cnt_q   <= '0;
    end else if (ar_hs) begin
      id_q    <= arid_i;
      idx_q   <= araddr_i[MEM_AW+2:3];
      len_q   <= arlen_i;
      burst_q <= arburst_i;
      err_q   <= req_err(araddr_i, arsize_i, arburst_i, MEM_AW);
      cnt_q   <= '0;
    end else if (w_hs) begin
      idx_q <= idx_next;
      cnt_q <= cnt_inc;
      if (wlast_i) bresp_q <= (err_q || !at_last) ? RESP_SLVERR : RESP_OKAY;
    end else if ((state == ST_RFETCH) || r_hs) begin
      idx_q <= idx_next;
      if (r_hs) cnt_q <= cnt_inc;
    end
  end

  sram_sp_be #(.AW(MEM_AW)) u_ram (
    .clk   (clk_i),
    .en    (ram_en),
    .we    (ram_we),
    .be    (wstrb_i),
    .addr  (idx_q),
    .wdata (wdata_i),
    .rdata (ram_rdata)
  );

endmodule
